keypad_emulator: RTL

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_emulator_if.sv | 13 +
 rtl/bounce_timer.sv | 43 ++++
 rtl/keypad_emulator.sv | 119 +++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: emulator state encoding and key-code to row/column one-hot decode.
// The scanner uses the same decode, so a key code means the same thing on both sides of the wires.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        RELEASE_BOUNCE,
        GAP
    } kp_state_t;

    function automatic logic [3:0] row_onehot(input logic [3:0] hex);
        return 4'b0001 << hex[3:2];
    endfunction

    function automatic logic [3:0] col_onehot(input logic [3:0] hex);
        return 4'b0001 << hex[1:0];
    endfunction

    // Zero-length intervals would stall the countdown, so they are stretched to one cycle.
    function automatic logic [15:0] at_least_one(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Command handshake plus the scanner-facing column strobe / row sense pair.
// master = command source and scanner, slave = emulator.
interface keypad_emulator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_hex;
    logic [15:0] cmd_hold;
    logic [3:0]  JBO;
    logic [3:0]  JBI;

    modport master (output cmd_valid, cmd_hex, cmd_hold, JBO, input cmd_ready, JBI);
    modport slave  (input cmd_valid, cmd_hex, cmd_hold, JBO, output cmd_ready, JBI);
endinterface

// File: rtl/bounce_timer.sv
// Countdown timer with bounce-toggle counting; expire fires when the count reaches 1.
// Latency: expire/toggle/last are combinational from the registered count.
// Backpressure: none; load always wins over the internal reload.
module bounce_timer #(
    parameter int BOUNCE_EDGES  = 4,
    parameter int BOUNCE_PERIOD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        bounce,
    output logic        expire,
    output logic        toggle,
    output logic        last
);
    localparam logic [15:0] PERIOD   = 16'(BOUNCE_PERIOD);
    localparam logic [15:0] LAST_IDX = 16'(BOUNCE_EDGES - 1);

    logic [15:0] cnt;
    logic [15:0] tog_cnt;

    assign expire = (cnt == 16'd1);
    assign toggle = bounce && expire;
    assign last   = toggle && (tog_cnt == LAST_IDX);

    // Count stops at 1 rather than wrapping; the owner always reloads on expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 16'd0;
            tog_cnt <= 16'd0;
        end else if (load) begin
            cnt     <= load_val;
            tog_cnt <= 16'd0;
        end else if (toggle) begin
            cnt     <= PERIOD;
            tog_cnt <= tog_cnt + 16'd1;
        end else if (cnt > 16'd1) begin
            cnt     <= cnt - 16'd1;
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Emulates one keypad contact (with bounce) on a scanned 4x4 matrix, one command at a time.
// Latency: contact closes on the accept edge; JBI is combinational from JBO and registered state.
// Backpressure: cmd_ready only in IDLE; commands presented while busy are neither taken nor queued.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int BOUNCE_EDGES  = 4,
    parameter int BOUNCE_PERIOD = 16,
    parameter int GAP_CYCLES    = 32
) (
    input  logic               clk,
    input  logic               reset,
    keypad_emulator_if.slave   kif,
    output logic               pressed,
    output logic               done
);
    localparam logic [15:0] PERIOD_LOAD = 16'(BOUNCE_PERIOD);
    localparam logic [15:0] GAP_LOAD    = (GAP_CYCLES < 1) ? 16'd1 : 16'(GAP_CYCLES);

    kp_state_t   state, state_nxt;
    logic        pressed_nxt;
    logic [3:0]  key_q;
    logic [15:0] hold_q;
    logic        accept;
    logic        load;
    logic [15:0] load_val;
    logic        bounce;
    logic        expire, toggle, last;

    assign kif.cmd_ready = (state == IDLE);
    assign accept        = kif.cmd_valid && kif.cmd_ready;
    assign bounce        = (state == PRESS_BOUNCE) || (state == RELEASE_BOUNCE);

    // A non-one-hot strobe can never equal a column one-hot, so it always reads back zero.
    assign kif.JBI = (pressed && (kif.JBO == col_onehot(key_q))) ? row_onehot(key_q) : 4'b0000;

    bounce_timer #(
        .BOUNCE_EDGES  (BOUNCE_EDGES),
        .BOUNCE_PERIOD (BOUNCE_PERIOD)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .bounce   (bounce),
        .expire   (expire),
        .toggle   (toggle),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pressed <= 1'b0;
            key_q   <= 4'd0;
            hold_q  <= 16'd0;
        end else begin
            state   <= state_nxt;
            pressed <= pressed_nxt;
            if (accept) begin
                key_q  <= kif.cmd_hex;
                hold_q <= kif.cmd_hold;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        pressed_nxt = pressed;
        done        = 1'b0;
        load_val    = 16'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    pressed_nxt = 1'b1;
                    state_nxt   = (BOUNCE_EDGES == 0) ? HOLD : PRESS_BOUNCE;
                end
            end
            PRESS_BOUNCE: begin
                if (toggle) begin
                    pressed_nxt = last ? 1'b1 : ~pressed;
                    if (last) state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (expire) begin
                    pressed_nxt = 1'b0;
                    state_nxt   = (BOUNCE_EDGES == 0) ? GAP : RELEASE_BOUNCE;
                end
            end
            RELEASE_BOUNCE: begin
                if (toggle) begin
                    pressed_nxt = last ? 1'b0 : ~pressed;
                    if (last) state_nxt = GAP;
                end
            end
            GAP: begin
                if (expire) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                pressed_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase

        // Every state entry reloads the timer; hold comes straight from the bus on the accept edge.
        load = (state_nxt != state);
        case (state_nxt)
            PRESS_BOUNCE, RELEASE_BOUNCE: load_val = PERIOD_LOAD;
            HOLD:    load_val = at_least_one((state == IDLE) ? kif.cmd_hold : hold_q);
            GAP:     load_val = GAP_LOAD;
            default: load_val = 16'd0;
        endcase
    end

endmodule
